// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core: machine word, fetch FSM states, PC step.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP_C = 32'd4;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: saturating counts of delivered instructions and redirects.
// Latency: count visible the cycle after the event. Backpressure: none, pure observer.
// Built only when FETCH_PERF_EN is defined.
module fetch_perf_ctr (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fetch_inc,
    input  logic        redirect_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (fetch_inc && (fetch_count != '1))
                fetch_count <= fetch_count + 32'd1;
            if (redirect_inc && (redirect_count != '1))
                redirect_count <= redirect_count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, requests imem words and drives IF/ID enable/flush.
// Latency: a hit is handed to IF/ID the same cycle (1 instr/cycle sequential).
// Backpressure: stall holds the PC with the request open; a miss holds the address until ihit.
// Optional FETCH_PERF_EN adds fetch_count/redirect_count ports.
import cpu_types_pkg::*;

module fetch_unit #(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = PC_STEP_C
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fd_enable,
    output logic        fd_flush,
    output logic [31:0] npc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    word_t        pend_pc, pend_nxt;

    assign imemREN  = (state != HALTED);
    assign imemaddr = pc;
    assign npc      = pc + PC_STEP;
    assign halted   = (state == HALTED);

    // Enable only for a clean hit in RUN; any higher-priority event turns the slot into a bubble,
    // so enable and flush can never be raised together.
    assign fd_enable = (state == RUN) && !halt && !redirect && !stall && ihit;
    assign fd_flush  = (state == HALTED) || (state == DRAIN) ||
                       ((state == RUN) && (halt || redirect));

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_pc;
        case (state)
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (redirect) begin
                    if (ihit) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        // The miss is still outstanding: keep the address stable until it returns.
                        pend_nxt  = redirect_pc;
                        state_nxt = DRAIN;
                    end
                end else if (!stall && ihit) begin
                    pc_nxt = pc + PC_STEP;
                end
            end
            DRAIN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (ihit) begin
                    pc_nxt    = redirect ? redirect_pc : pend_pc;
                    state_nxt = RUN;
                end else if (redirect) begin
                    pend_nxt = redirect_pc;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            pc      <= PC_INIT;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf (
        .CLK            (CLK),
        .RST            (RST),
        .fetch_inc      (fd_enable),
        .redirect_inc   (redirect && !halted),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle expected outputs go to a scoreboard queue, checked mid-cycle.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fd_enable;
    logic        fd_flush;
    logic [31:0] npc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       nm;
        logic        ren;
        logic [31:0] addr;
        logic        en;
        logic        fl;
        logic [31:0] npc;
        logic        hd;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .ihit           (ihit),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fd_enable      (fd_enable),
        .fd_flush       (fd_flush),
        .npc            (npc),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
`endif
    );

    // Scoreboard: pop one expectation per cycle, in the middle of the cycle.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors += 6;
            if (imemREN !== e.ren) begin
                miscompares++;
                $display("FAIL %s imemREN got %b want %b", e.nm, imemREN, e.ren);
            end
            if (imemaddr !== e.addr) begin
                miscompares++;
                $display("FAIL %s imemaddr got %h want %h", e.nm, imemaddr, e.addr);
            end
            if (fd_enable !== e.en) begin
                miscompares++;
                $display("FAIL %s fd_enable got %b want %b", e.nm, fd_enable, e.en);
            end
            if (fd_flush !== e.fl) begin
                miscompares++;
                $display("FAIL %s fd_flush got %b want %b", e.nm, fd_flush, e.fl);
            end
            if (npc !== e.npc) begin
                miscompares++;
                $display("FAIL %s npc got %h want %h", e.nm, npc, e.npc);
            end
            if (halted !== e.hd) begin
                miscompares++;
                $display("FAIL %s halted got %b want %b", e.nm, halted, e.hd);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic drive(input string nm, input logic ih, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic hl,
                         input logic ren, input logic [31:0] addr,
                         input logic en, input logic fl, input logic hd);
        exp_t e;
        ihit        = ih;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        e.nm   = nm;
        e.ren  = ren;
        e.addr = addr;
        e.en   = en;
        e.fl   = fl;
        e.npc  = addr + 32'd4;
        e.hd   = hd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        ihit        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST         = 1'b1;
        ihit        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        #2;
        vectors += 5;
        if (imemREN !== 1'b1) begin miscompares++; $display("FAIL reset imemREN got %b want 1", imemREN); end
        if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL reset imemaddr got %h want 0", imemaddr); end
        if (fd_enable !== 1'b0) begin miscompares++; $display("FAIL reset fd_enable got %b want 0", fd_enable); end
        if (fd_flush !== 1'b0) begin miscompares++; $display("FAIL reset fd_flush got %b want 0", fd_flush); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL reset halted got %b want 0", halted); end
`ifdef FETCH_PERF_EN
        vectors++;
        if (fetch_count !== 32'h0 || redirect_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset counters got %h/%h want 0/0", fetch_count, redirect_count);
        end
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++)
            drive("seq", 1, 0, 0, 0, 0, 1, 32'(i * 4), 1, 0, 0);
    endtask

    task automatic test_stall();
        drive("stall0", 1, 1, 0, 0, 0, 1, 32'h10, 0, 0, 0);
        drive("stall1", 1, 1, 0, 0, 0, 1, 32'h10, 0, 0, 0);
        drive("stall_rel", 1, 0, 0, 0, 0, 1, 32'h10, 1, 0, 0);
        drive("stall_next", 1, 0, 0, 0, 0, 1, 32'h14, 1, 0, 0);
    endtask

    task automatic test_redirect_hit();
        drive("rh_seq", 1, 0, 0, 0, 0, 1, 32'h18, 1, 0, 0);
        drive("rh_seq", 1, 0, 0, 0, 0, 1, 32'h1C, 1, 0, 0);
        drive("rh_redir", 1, 0, 1, 32'h40, 0, 1, 32'h20, 0, 1, 0);
        drive("rh_target", 1, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0);
        drive("rh_unalign", 1, 1, 1, 32'h43, 0, 1, 32'h44, 0, 1, 0);
        drive("rh_unalign_tgt", 1, 0, 0, 0, 0, 1, 32'h43, 1, 0, 0);
    endtask

    task automatic test_drain();
        do_reset();
        drive("dr_seq", 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0);
        drive("dr_seq", 1, 0, 0, 0, 0, 1, 32'h4, 1, 0, 0);
        drive("dr_miss0", 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0);
        drive("dr_miss1_redir", 0, 0, 1, 32'h100, 0, 1, 32'h8, 0, 1, 0);
        drive("dr_miss2", 0, 0, 0, 0, 0, 1, 32'h8, 0, 1, 0);
        drive("dr_hit_drop", 1, 0, 0, 0, 0, 1, 32'h8, 0, 1, 0);
        drive("dr_target", 1, 0, 0, 0, 0, 1, 32'h100, 1, 0, 0);
    endtask

    task automatic test_drain_override();
        drive("do_redir_a", 0, 0, 1, 32'h300, 0, 1, 32'h104, 0, 1, 0);
        drive("do_redir_b", 0, 0, 1, 32'h380, 0, 1, 32'h104, 0, 1, 0);
        drive("do_hit", 1, 0, 0, 0, 0, 1, 32'h104, 0, 1, 0);
        drive("do_target", 1, 0, 0, 0, 0, 1, 32'h380, 1, 0, 0);
        drive("do_redir_c", 0, 0, 1, 32'h600, 0, 1, 32'h384, 0, 1, 0);
        drive("do_hit_redir", 1, 0, 1, 32'h700, 0, 1, 32'h384, 0, 1, 0);
        drive("do_target2", 1, 0, 0, 0, 0, 1, 32'h700, 1, 0, 0);
    endtask

    task automatic test_wrap();
`ifdef FETCH_PERF_EN
        logic [31:0] f0, r0;
        r0 = redirect_count;
`endif
        drive("wr_redir", 1, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h704, 0, 1, 0);
`ifdef FETCH_PERF_EN
        f0 = fetch_count;
        vectors++;
        if (redirect_count !== r0 + 32'd1) begin
            miscompares++;
            $display("FAIL wrap redirect_count got %h want %h", redirect_count, r0 + 32'd1);
        end
`endif
        drive("wr_top", 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
`ifdef FETCH_PERF_EN
        vectors++;
        if (fetch_count !== f0 + 32'd1) begin
            miscompares++;
            $display("FAIL wrap fetch_count got %h want %h", fetch_count, f0 + 32'd1);
        end
`endif
        drive("wr_zero", 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    endtask

    task automatic test_halt();
`ifdef FETCH_PERF_EN
        logic [31:0] r0;
`endif
        drive("ht_redir", 0, 0, 1, 32'h500, 0, 1, 32'h0, 0, 1, 0);
        drive("ht_halt", 0, 0, 0, 0, 1, 1, 32'h0, 0, 1, 0);
`ifdef FETCH_PERF_EN
        r0 = redirect_count;
`endif
        drive("ht_halted0", 1, 0, 1, 32'h900, 0, 0, 32'h0, 0, 1, 1);
        drive("ht_halted1", 1, 0, 1, 32'h900, 0, 0, 32'h0, 0, 1, 1);
`ifdef FETCH_PERF_EN
        vectors++;
        if (redirect_count !== r0) begin
            miscompares++;
            $display("FAIL halt redirect_count got %h want %h", redirect_count, r0);
        end
`endif
        do_reset();
        vectors += 3;
        if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL halt_rst imemaddr got %h want 0", imemaddr); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_rst halted got %b want 0", halted); end
        if (imemREN !== 1'b1) begin miscompares++; $display("FAIL halt_rst imemREN got %b want 1", imemREN); end
        drive("ht_after", 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_hit();
        test_drain();
        test_drain_override();
        test_wrap();
        test_halt();
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
